mat_ops_engine: RTL and testbench

- Parametrised successor to the fixed three-SRAM matrix-ops controller.
- Streams `i_len` packed words of N signed lanes from SRAM A and SRAM B and computes one of three modes: element-wise add, element-wise multiply, or multiply-accumulate dot product.
- Applies optional ReLU and writes results to SRAM C.
- Software starts it through `i_start`; completion is a one-cycle `o_done` pulse.

---
 rtl/mat_ops_engine.sv | 176 +++++++++++++++++
 tb/tb_mat_ops_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_ops_engine.sv
// mat_ops_engine: streams packed signed lanes from SRAM A/B, computes add/mul/MAC
// with saturation and optional ReLU, and writes the result words to SRAM C.
module mat_ops_engine #(
    parameter int DATA_LEN     = 8,
    parameter int N            = 4,
    parameter int ADDRESS_SIZE = 8,
    parameter int ACC_LEN      = 24
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    input  logic [1:0]                 i_mode,
    input  logic                       i_relu,
    input  logic [ADDRESS_SIZE-1:0]    i_len,
    input  logic [ADDRESS_SIZE-1:0]    i_base_A,
    input  logic [ADDRESS_SIZE-1:0]    i_base_B,
    input  logic [ADDRESS_SIZE-1:0]    i_base_C,
    input  logic [DATA_LEN*N-1:0]      i_read_data_A,
    input  logic [DATA_LEN*N-1:0]      i_read_data_B,
    input  logic [DATA_LEN*N-1:0]      i_read_data_C,
    output logic [ADDRESS_SIZE-1:0]    o_address_A,
    output logic [ADDRESS_SIZE-1:0]    o_address_B,
    output logic [ADDRESS_SIZE-1:0]    o_address_C,
    output logic                       o_wr_en_A,
    output logic                       o_wr_en_B,
    output logic                       o_wr_en_C,
    output logic [DATA_LEN*N-1:0]      o_write_data_A,
    output logic [DATA_LEN*N-1:0]      o_write_data_B,
    output logic [DATA_LEN*N-1:0]      o_write_data_C,
    output logic [2:0]                 o_state,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);
    localparam int WW = DATA_LEN * N;
    localparam int W  = ACC_LEN + 2;
    localparam logic signed [W-1:0] LMAX = W'((2 ** (DATA_LEN - 1)) - 1);
    localparam logic signed [W-1:0] LMIN = ~LMAX;
    localparam logic signed [W-1:0] AMAX = W'((2 ** (ACC_LEN - 1)) - 1);
    localparam logic signed [W-1:0] AMIN = ~AMAX;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        COMPUTE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic                      relu_q, relu_d;
    logic [ADDRESS_SIZE-1:0]   len_q, len_d, idx_q, idx_d;
    logic [ADDRESS_SIZE-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic signed [ACC_LEN-1:0] acc_q, acc_d, acc_sat;
    logic [WW-1:0]             wdata_q, wdata_d, ew, mac_word;
    logic signed [W-1:0]       dot, acc_sum;
    logic                      last;
    logic                      unused_c;

    function automatic logic [DATA_LEN-1:0] clamp(input logic signed [W-1:0] v, input logic relu);
        logic [DATA_LEN-1:0] s;
        s = (v > LMAX) ? LMAX[DATA_LEN-1:0] : (v < LMIN) ? LMIN[DATA_LEN-1:0] : v[DATA_LEN-1:0];
        return (relu && s[DATA_LEN-1]) ? '0 : s;
    endfunction

    // Lanes are widened to the accumulator width so every sum/product is exact before saturation
    always_comb begin : lanes
        logic signed [W-1:0] a, b;
        a   = '0;
        b   = '0;
        ew  = '0;
        dot = '0;
        for (int k = 0; k < N; k++) begin
            a = W'($signed(i_read_data_A[k*DATA_LEN +: DATA_LEN]));
            b = W'($signed(i_read_data_B[k*DATA_LEN +: DATA_LEN]));
            ew[k*DATA_LEN +: DATA_LEN] = clamp((mode_q == 2'd1) ? a * b : a + b, relu_q);
            dot = dot + a * b;
        end
        acc_sum  = W'(acc_q) + dot;
        acc_sat  = (acc_sum > AMAX) ? AMAX[ACC_LEN-1:0] :
                   (acc_sum < AMIN) ? AMIN[ACC_LEN-1:0] : acc_sum[ACC_LEN-1:0];
        mac_word = WW'(clamp(W'(acc_sat), relu_q));
    end

    assign last = !((idx_q + ADDRESS_SIZE'(1)) < len_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        relu_d   = relu_q;
        len_d    = len_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: if (i_start) begin
                mode_d   = i_mode;
                relu_d   = i_relu;
                len_d    = i_len;
                base_a_d = i_base_A;
                base_b_d = i_base_B;
                base_c_d = i_base_C;
                idx_d    = '0;
                if (i_mode == 2'd3 || i_len == '0) state_d = DONE;
                else begin
                    state_d = READ;
                    acc_d   = '0;
                end
            end
            READ: state_d = WAIT;
            WAIT: state_d = COMPUTE;
            COMPUTE: if (mode_q == 2'd2) begin
                acc_d   = acc_sat;
                wdata_d = last ? mac_word : wdata_q;
                idx_d   = last ? idx_q : idx_q + ADDRESS_SIZE'(1);
                state_d = last ? WRITE : READ;
            end else begin
                wdata_d = ew;
                state_d = WRITE;
            end
            WRITE: if (mode_q != 2'd2 && !last) begin
                idx_d   = idx_q + ADDRESS_SIZE'(1);
                state_d = READ;
            end else state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            relu_q   <= 1'b0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            relu_q   <= relu_d;
            len_q    <= len_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_c_q <= base_c_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            wdata_q  <= wdata_d;
        end
    end

    // MAC produces a single word, always at the C base address
    assign o_address_A    = base_a_q + idx_q;
    assign o_address_B    = base_b_q + idx_q;
    assign o_address_C    = (mode_q == 2'd2) ? base_c_q : base_c_q + idx_q;
    assign o_wr_en_A      = 1'b0;
    assign o_wr_en_B      = 1'b0;
    assign o_write_data_A = '0;
    assign o_write_data_B = '0;
    assign o_wr_en_C      = (state_q == WRITE);
    assign o_write_data_C = wdata_q;
    assign o_state        = state_q;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);
    assign o_error        = (state_q == DONE) && (mode_q == 2'd3);
    assign unused_c       = ^i_read_data_C;
endmodule

// File: tb/tb_mat_ops_engine.sv
// tb_mat_ops_engine: randomized and directed checks of mat_ops_engine against
// a word-level reference model with behavioural SRAMs.
module tb_mat_ops_engine;
    logic        i_clk = 1'b0, i_rstn = 1'b0, i_start = 1'b0, i_relu = 1'b0;
    logic [1:0]  i_mode = '0;
    logic [7:0]  i_len = '0, i_base_A = '0, i_base_B = '0, i_base_C = '0;
    logic [31:0] i_read_data_A = '0, i_read_data_B = '0, i_read_data_C = '0;
    logic [7:0]  o_address_A, o_address_B, o_address_C;
    logic        o_wr_en_A, o_wr_en_B, o_wr_en_C;
    logic [31:0] o_write_data_A, o_write_data_B, o_write_data_C;
    logic [2:0]  o_state;
    logic        o_busy, o_done, o_error;

    logic [31:0] mem_a[256], mem_b[256], mem_c[256];
    logic [39:0] wr_q[$];
    logic [15:0] rd_q[$];
    int n_cmp = 0, n_bad = 0;

    mat_ops_engine #(.DATA_LEN(8), .N(4), .ADDRESS_SIZE(8), .ACC_LEN(24)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_mode(i_mode), .i_relu(i_relu),
        .i_len(i_len), .i_base_A(i_base_A), .i_base_B(i_base_B), .i_base_C(i_base_C),
        .i_read_data_A(i_read_data_A), .i_read_data_B(i_read_data_B), .i_read_data_C(i_read_data_C),
        .o_address_A(o_address_A), .o_address_B(o_address_B), .o_address_C(o_address_C),
        .o_wr_en_A(o_wr_en_A), .o_wr_en_B(o_wr_en_B), .o_wr_en_C(o_wr_en_C),
        .o_write_data_A(o_write_data_A), .o_write_data_B(o_write_data_B),
        .o_write_data_C(o_write_data_C), .o_state(o_state), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        i_read_data_A <= mem_a[o_address_A];
        i_read_data_B <= mem_b[o_address_B];
        if (o_wr_en_C) begin
            mem_c[o_address_C] <= o_write_data_C;
            wr_q.push_back({o_address_C, o_write_data_C});
        end
        if (o_state == 3'd1) rd_q.push_back({o_address_A, o_address_B});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    function automatic int lane(input logic [31:0] w, input int k);
        return int'($signed(w[k*8 +: 8]));
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic logic [7:0] fin(input int v, input bit relu);
        int s;
        s = clampi(v, -128, 127);
        if (relu && s < 0) s = 0;
        return s[7:0];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
    endtask

    // One full operation: build expected writes/reads/latency, run it, compare
    task automatic run_op(input int mode, input bit relu, input int len, input int ba,
                          input int bb, input int bc, input bit poke);
        logic [39:0] exp_w[$];
        logic [15:0] exp_r[$];
        logic [31:0] wa, wb, r;
        int acc, lat, cyc, a, b;
        bit legal;
        legal = (mode != 3) && (len != 0);
        acc = 0;
        if (legal) for (int i = 0; i < len; i++) begin
            wa = mem_a[(ba + i) % 256];
            wb = mem_b[(bb + i) % 256];
            exp_r.push_back({8'((ba + i) % 256), 8'((bb + i) % 256)});
            r = '0;
            for (int k = 0; k < 4; k++) begin
                a = lane(wa, k);
                b = lane(wb, k);
                if (mode == 2) acc += a * b;
                else r[k*8 +: 8] = fin((mode == 1) ? a * b : a + b, relu);
            end
            if (mode == 2) acc = clampi(acc, -(1 << 23), (1 << 23) - 1);
            else exp_w.push_back({8'((bc + i) % 256), r});
        end
        if (legal && mode == 2) exp_w.push_back({8'(bc % 256), 24'd0, fin(acc, relu)});
        lat = !legal ? 1 : (mode == 2) ? 3 * len + 2 : 4 * len + 1;
        wr_q.delete();
        rd_q.delete();
        @(negedge i_clk);
        i_start  = 1'b1;
        i_mode   = 2'(mode);
        i_relu   = relu;
        i_len    = 8'(len);
        i_base_A = 8'(ba);
        i_base_B = 8'(bb);
        i_base_C = 8'(bc);
        @(negedge i_clk);
        cyc = 1;
        i_start = 1'b0;
        while (o_done !== 1'b1 && cyc < 1000) begin
            i_start  = poke && (cyc == 1);
            i_mode   = 2'($urandom);
            i_relu   = 1'($urandom);
            i_len    = 8'($urandom);
            i_base_A = 8'($urandom);
            i_base_B = 8'($urandom);
            i_base_C = 8'($urandom);
            @(negedge i_clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("error", o_error, mode == 3);
        i_start = poke;
        @(negedge i_clk);
        i_start = 1'b0;
        check("done_pulse", o_done, 1'b0);
        check("idle_after", o_state, 3'd0);
        @(negedge i_clk);
        check("stay_idle", o_busy, 1'b0);
        check("n_writes", wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) check("write", wr_q[i], exp_w[i]);
        check("n_reads", rd_q.size(), exp_r.size());
        for (int i = 0; i < exp_r.size() && i < rd_q.size(); i++) check("read_addr", rd_q[i], exp_r[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, o_state, 3'd0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_error"}, o_error, 1'b0);
        check({tag, "_wr_en"}, {o_wr_en_A, o_wr_en_B, o_wr_en_C}, 3'b000);
        check({tag, "_wdata"}, {o_write_data_A, o_write_data_B, o_write_data_C}, 96'd0);
        check({tag, "_addr"}, {o_address_A, o_address_B, o_address_C}, 24'd0);
    endtask

    task automatic reset_mid();
        int cyc;
        fill_random();
        wr_q.delete();
        @(negedge i_clk);
        i_start = 1'b1; i_mode = 2'd0; i_relu = 1'b0; i_len = 8'd4;
        i_base_A = 8'h11; i_base_B = 8'h22; i_base_C = 8'h33;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (!(wr_q.size() == 1 && o_state == 3'd4) && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        check("reach_word1_write", cyc < 100, 1'b1);
        #1 i_rstn = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge i_clk);
        check("no_write_in_rst", wr_q.size(), 1);
        i_rstn = 1'b1;
    endtask

    initial begin
        int m;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rstn = 1'b1;

        mem_a[8'h00] = pk(1, 2, 3, 4);
        mem_a[8'h01] = pk(127, -128, 0, 5);
        mem_b[8'h40] = pk(1, 1, 1, 1);
        mem_b[8'h41] = pk(1, -1, 0, -10);
        run_op(0, 0, 2, 'h00, 'h40, 'h10, 0);
        check("add_c10", mem_c[8'h10], pk(2, 3, 4, 5));
        check("add_c11", mem_c[8'h11], pk(127, -128, 0, -5));

        mem_a[8'h20] = pk(16, -16, 3, -2);
        mem_b[8'h30] = pk(16, 16, 3, 3);
        run_op(1, 1, 1, 'h20, 'h30, 'h50, 1);
        check("mul_relu", mem_c[8'h50], pk(127, 0, 9, 0));

        for (int i = 'h60; i < 'h63; i++) begin
            mem_a[i] = pk(2, 2, 2, 2);
            mem_b[i] = pk(2, 2, 2, 2);
        end
        run_op(2, 0, 3, 'h60, 'h60, 'h70, 0);
        check("mac_48", mem_c[8'h70], pk(48, 0, 0, 0));
        mem_a[8'h80] = pk(100, 100, 100, 100);
        mem_b[8'h80] = pk(100, 100, 100, 100);
        run_op(2, 0, 1, 'h80, 'h80, 'h90, 0);
        check("mac_sat8", mem_c[8'h90], pk(127, 0, 0, 0));

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h80808080;
            mem_b[i] = 32'h7f7f7f7f;
        end
        run_op(2, 0, 200, 0, 0, 'hA0, 0);
        check("mac_acc_sat", mem_c[8'hA0], pk(-128, 0, 0, 0));

        run_op(0, 0, 0, 1, 2, 3, 1);
        run_op(3, 0, 5, 1, 2, 3, 1);

        fill_random();
        run_op(0, 0, 2, 'hFF, 'h03, 'hFE, 1);

        reset_mid();
        fill_random();
        run_op(0, 1, 4, 'h11, 'h22, 'h33, 0);

        for (int t = 0; t < 25; t++) begin
            fill_random();
            m = $urandom_range(0, 7);
            run_op((m > 3) ? m % 3 : m, 1'($urandom), $urandom_range(0, 6),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
